io_bus_ctrl: RTL

IO_BUS_CTRL -- requirements
Module: io_bus_ctrl

---
 rtl/io_bus_ctrl.sv | 215 +++++++++++++++++++++
 1 files changed

// File: rtl/io_bus_ctrl.sv
// ============================================================================
//  Module      : io_bus_ctrl
//  Description : Memory-mapped IO controller. It decodes CPU loads and stores
//                into LED and seven-segment registers, a keyboard scancode
//                FIFO, a character-RAM port and a 32-bit timer with an
//                interrupt.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module io_bus_ctrl #(
  parameter int LED_W     = 5,
  parameter int SEG_W     = 16,
  parameter int KBD_W     = 16,
  parameter int KBD_DEPTH = 8,
  parameter int VGA_AW    = 12
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_enable,
  input  logic              i_is_store,
  input  logic              i_is_load,
  input  logic [31:0]       i_addr,
  input  logic [31:0]       i_mem_wdata,
  input  logic [31:0]       i_mem_rdata,
  input  logic              i_kbd_valid,
  input  logic [KBD_W-1:0]  i_kbd_data,
  input  logic [7:0]        i_vga_rdata,
  output logic [LED_W-1:0]  o_leds,
  output logic [SEG_W-1:0]  o_segments,
  output logic [VGA_AW-1:0] o_vga_addr,
  output logic [7:0]        o_vga_wdata,
  output logic              o_vga_we,
  output logic              o_vga_re,
  output logic              o_timer_irq,
  output logic [31:0]       o_rdata
);

  // FIFO pointer width and occupancy width (occupancy must reach KBD_DEPTH)
  localparam int              c_PW   = (KBD_DEPTH > 1) ? $clog2(KBD_DEPTH) : 1;
  localparam int              c_CW   = c_PW + 1;
  localparam logic [c_CW-1:0] c_FULL = c_CW'(KBD_DEPTH);

  // ---------------------------------------------------------------- decode
  logic w_wr, w_rd;
  logic w_sel_kbd, w_sel_led, w_sel_seg, w_sel_vga, w_sel_tmr;
  logic w_unused;

  // A simultaneous load and store is a store only.
  assign w_wr = i_enable & i_is_store;
  assign w_rd = i_enable & i_is_load & ~i_is_store;

  // Word-address select bits resolved by priority KBD > LED > SEG > VGA > TMR.
  assign w_sel_kbd = i_addr[15];
  assign w_sel_led = i_addr[14] & ~i_addr[15];
  assign w_sel_seg = i_addr[13] & ~|i_addr[15:14];
  assign w_sel_vga = i_addr[12] & ~|i_addr[15:13];
  assign w_sel_tmr = i_addr[11] & ~|i_addr[15:12];

  assign w_unused = ^{i_addr, i_mem_wdata};

  // ------------------------------------------------------------ LED / SEG
  logic [LED_W-1:0] r_leds;
  logic [SEG_W-1:0] r_segments;

  // Output registers written by stores to their select region.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_leds     <= '0;
      r_segments <= '0;
    end else begin
      if (w_wr && w_sel_led) r_leds     <= i_mem_wdata[LED_W-1:0];
      if (w_wr && w_sel_seg) r_segments <= i_mem_wdata[SEG_W-1:0];
    end
  end

  assign o_leds     = r_leds;
  assign o_segments = r_segments;

  // ------------------------------------------------------------------ VGA
  assign o_vga_addr  = i_addr[VGA_AW-1:0];
  assign o_vga_wdata = i_mem_wdata[7:0];
  assign o_vga_we    = w_wr & w_sel_vga;
  assign o_vga_re    = w_rd & w_sel_vga;

  // ------------------------------------------------------------- keyboard
  logic [KBD_W-1:0] r_mem [KBD_DEPTH];
  logic [c_PW-1:0]  r_wptr, r_rptr;
  logic [c_CW-1:0]  r_count;
  logic             r_ovf;
  logic w_kbd_data_acc, w_kbd_stat_acc, w_empty, w_full;
  logic w_push, w_pop, w_flush, w_ovf_set, w_ovf_clr;

  assign w_kbd_data_acc = w_sel_kbd & ~i_addr[2];
  assign w_kbd_stat_acc = w_sel_kbd &  i_addr[2];
  assign w_empty        = (r_count == '0);
  assign w_full         = (r_count == c_FULL);
  assign w_pop          = w_rd & w_kbd_data_acc & ~w_empty;
  // A pop in the same cycle frees a slot, so a full FIFO still accepts.
  assign w_push         = i_kbd_valid & (~w_full | w_pop);
  assign w_flush        = w_wr & w_kbd_data_acc;
  assign w_ovf_set      = i_kbd_valid & w_full & ~w_pop;
  assign w_ovf_clr      = w_wr & w_kbd_stat_acc & i_mem_wdata[1];

  // Scancode storage; stale contents are harmless since pointers gate reads.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= i_kbd_data;
  end

  // FIFO pointers and occupancy; a DATA store flushes the queue.
  always_ff @(posedge clk) begin
    if (reset || w_flush) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Sticky overflow flag; a new overflow beats a same-cycle clear.
  always_ff @(posedge clk) begin
    if (reset)          r_ovf <= 1'b0;
    else if (w_ovf_set) r_ovf <= 1'b1;
    else if (w_ovf_clr) r_ovf <= 1'b0;
  end

  logic [6:0]  w_cnt7;
  logic [31:0] w_head32, w_kbd_word;

  // Zero-extended views of the FIFO head and occupancy for the read mux.
  always_comb begin
    w_cnt7                 = '0;
    w_cnt7[c_CW-1:0]       = r_count;
    w_head32               = '0;
    w_head32[KBD_W-1:0]    = r_mem[r_rptr];
    if (w_kbd_stat_acc)    w_kbd_word = {23'd0, w_cnt7, r_ovf, w_empty};
    else if (w_empty)      w_kbd_word = 32'd0;
    else                   w_kbd_word = w_head32;
  end

  // ---------------------------------------------------------------- timer
  logic [31:0] r_mtime, r_mtimecmp;
  logic        r_ie, r_pending;
  logic        w_tmr_wr;
  logic [31:0] w_tmr_word;

  assign w_tmr_wr = w_wr & w_sel_tmr;

  // Free-running counter; a store replaces the increment for that cycle.
  always_ff @(posedge clk) begin
    if (reset)                                r_mtime <= '0;
    else if (w_tmr_wr && i_addr[3:2] == 2'd0) r_mtime <= i_mem_wdata;
    else                                      r_mtime <= r_mtime + 32'd1;
  end

  // Compare value and interrupt enable.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_mtimecmp <= '1;
      r_ie       <= 1'b0;
    end else begin
      if (w_tmr_wr && i_addr[3:2] == 2'd1) r_mtimecmp <= i_mem_wdata;
      if (w_tmr_wr && i_addr[3:2] == 2'd2) r_ie       <= i_mem_wdata[0];
    end
  end

  // Pending latches on a match of the current count; a match beats a clear.
  always_ff @(posedge clk) begin
    if (reset)                         r_pending <= 1'b0;
    else if (r_mtime == r_mtimecmp)    r_pending <= 1'b1;
    else if (w_tmr_wr && i_addr[3:2] == 2'd3 && i_mem_wdata[0])
                                       r_pending <= 1'b0;
  end

  assign o_timer_irq = r_pending & r_ie;

  // Timer register read selection.
  always_comb begin
    case (i_addr[3:2])
      2'd0:    w_tmr_word = r_mtime;
      2'd1:    w_tmr_word = r_mtimecmp;
      2'd2:    w_tmr_word = {31'd0, r_ie};
      default: w_tmr_word = {31'd0, r_pending};
    endcase
  end

  // ------------------------------------------------------------- read mux
  logic [31:0] w_led32, w_seg32;

  // CPU read data: device word when an IO region is loaded, else RAM data.
  always_comb begin
    w_led32              = '0;
    w_led32[LED_W-1:0]   = r_leds;
    w_seg32              = '0;
    w_seg32[SEG_W-1:0]   = r_segments;
    o_rdata              = i_mem_rdata;
    if (w_rd) begin
      if (w_sel_kbd)      o_rdata = w_kbd_word;
      else if (w_sel_led) o_rdata = w_led32;
      else if (w_sel_seg) o_rdata = w_seg32;
      else if (w_sel_vga) o_rdata = {4{i_vga_rdata}};
      else if (w_sel_tmr) o_rdata = w_tmr_word;
    end
  end

endmodule

`default_nettype wire
